// File: rtl/maj_net_sched_if.sv
// Handshake and configuration bus of the maj_net_sched majority-inverter network evaluator.
interface maj_net_sched_if #(
    parameter int NODES = 8
);
    localparam int SW  = $clog2(NODES + 7);
    localparam int OPW = SW + 1;
    localparam int AW  = $clog2(NODES + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [5:0]           x;
    logic                 out_valid;
    logic                 out_ready;
    logic                 y;
    logic                 cfg_we;
    logic [AW-1:0]        cfg_addr;
    logic [3*OPW-1:0]     cfg_data;
    logic                 cfg_err;

    modport master (
        output in_valid, x, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, y, cfg_err
    );

    modport slave (
        input  in_valid, x, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, y, cfg_err
    );
endinterface

// File: rtl/maj_net_sched.sv
// Sequential MIG evaluator: one shared MAJ unit walks a gate program one node per cycle.
// Optional MAJ_SCHED_PERF_EN adds a saturating count of completed output handshakes.
module maj_net_sched #(
    parameter int NODES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    maj_net_sched_if.slave    bus
`ifdef MAJ_SCHED_PERF_EN
    ,
    output logic [15:0]       perf_cnt
`endif
);
    localparam int SW   = $clog2(NODES + 7);
    localparam int OPW  = SW + 1;
    localparam int AW   = $clog2(NODES + 1);
    localparam int IW   = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int NSIG = 1 << SW;
    localparam int GW   = 3 * OPW;
    localparam logic [AW-1:0] NODES_A = AW'(NODES);
    localparam logic [AW-1:0] PC_ONE  = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r, state_nx_s;
    logic                in_ready_r, out_valid_r, y_r, cfg_err_r;
    logic                in_ready_nx_s, out_valid_nx_s, load_y_s;
    logic [GW-1:0]       prog_r [NODES];
    logic [AW-1:0]       len_r, len_wr_s;
    logic [OPW-1:0]      out_sel_r;
    logic [5:0]          x_r, x_nx_s;
    logic [NODES-1:0]    node_r, node_nx_s;
    logic [AW-1:0]       pc_r, pc_nx_s;
    logic [GW-1:0]       gate_s;
    logic [NSIG-1:0]     sig_s, sig_nx_s;
    logic                acc_s, cfg_ok_s, last_s, y_nx_s;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Index 0 is constant 0, 1..6 the inputs, 7+j node j; anything above reads 0.
    function automatic logic [NSIG-1:0] build_sig(input logic [5:0] xv, input logic [NODES-1:0] nv);
        logic [NSIG-1:0] s;
        s = {NSIG{1'b0}};
        for (int i = 0; i < 6; i++) s[i+1] = xv[i];
        for (int j = 0; j < NODES; j++) s[j+7] = nv[j];
        return s;
    endfunction

    function automatic logic op_val(input logic [OPW-1:0] op, input logic [NSIG-1:0] s);
        return s[op[SW-1:0]] ^ op[SW];
    endfunction

    // Accept and config-write qualification.
    always_comb begin
        acc_s    = (state_r == ST_IDLE) && bus.in_valid;
        cfg_ok_s = bus.cfg_we && (state_r == ST_IDLE) && !acc_s && (bus.cfg_addr <= NODES_A);
        last_s   = (pc_r == (len_r - PC_ONE));
        if (bus.cfg_data[OPW +: AW] > NODES_A) begin
            len_wr_s = NODES_A;
        end else begin
            len_wr_s = bus.cfg_data[OPW +: AW];
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_s) begin
                    if (len_r == {AW{1'b0}}) state_nx_s = ST_DONE;
                    else                     state_nx_s = ST_EVAL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EVAL: begin
                if (last_s) state_nx_s = ST_DONE;
                else        state_nx_s = ST_EVAL;
            end
            ST_DONE: begin
                if (bus.out_ready) state_nx_s = ST_IDLE;
                else               state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the handshake flags come straight from flops.
    always_comb begin
        in_ready_nx_s  = (state_nx_s == ST_IDLE);
        out_valid_nx_s = (state_nx_s == ST_DONE);
        load_y_s       = (state_nx_s == ST_DONE) && (state_r != ST_DONE);
    end

    // State and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            y_r         <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
            if (load_y_s) y_r <= y_nx_s;
        end
    end

    // Datapath next values; y is taken from the post-edge signal set so the last gate counts.
    always_comb begin
        x_nx_s    = x_r;
        node_nx_s = node_r;
        pc_nx_s   = pc_r;
        sig_s     = build_sig(x_r, node_r);
        gate_s    = prog_r[pc_r[IW-1:0]];
        case (state_r)
            ST_IDLE: begin
                if (acc_s) begin
                    x_nx_s    = bus.x;
                    node_nx_s = {NODES{1'b0}};
                    pc_nx_s   = {AW{1'b0}};
                end else begin
                    x_nx_s    = x_r;
                end
            end
            ST_EVAL: begin
                node_nx_s[pc_r[IW-1:0]] = maj3(op_val(gate_s[OPW-1:0], sig_s),
                                               op_val(gate_s[2*OPW-1:OPW], sig_s),
                                               op_val(gate_s[3*OPW-1:2*OPW], sig_s));
                pc_nx_s = pc_r + PC_ONE;
            end
            ST_DONE: pc_nx_s = pc_r;
            default: begin
                node_nx_s = {NODES{1'b0}};
                pc_nx_s   = {AW{1'b0}};
            end
        endcase
        sig_nx_s = build_sig(x_nx_s, node_nx_s);
        y_nx_s   = op_val(out_sel_r, sig_nx_s);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r    <= 6'b000000;
            node_r <= {NODES{1'b0}};
            pc_r   <= {AW{1'b0}};
        end else begin
            x_r    <= x_nx_s;
            node_r <= node_nx_s;
            pc_r   <= pc_nx_s;
        end
    end

    // Program store, control word and write-reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NODES; k++) prog_r[k] <= {GW{1'b0}};
            len_r     <= {AW{1'b0}};
            out_sel_r <= {OPW{1'b0}};
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= bus.cfg_we && !cfg_ok_s;
            if (cfg_ok_s) begin
                if (bus.cfg_addr == NODES_A) begin
                    len_r     <= len_wr_s;
                    out_sel_r <= bus.cfg_data[OPW-1:0];
                end else begin
                    prog_r[bus.cfg_addr[IW-1:0]] <= bus.cfg_data;
                end
            end
        end
    end

`ifdef MAJ_SCHED_PERF_EN
    logic [15:0] perf_r;

    // Saturating count of completed output handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_r <= 16'h0000;
        end else if (out_valid_r && bus.out_ready && (perf_r != 16'hFFFF)) begin
            perf_r <= perf_r + 16'h0001;
        end
    end

    assign perf_cnt = perf_r;
`endif

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.y         = y_r;
    assign bus.cfg_err   = cfg_err_r;
endmodule

// File: tb/tb_maj_net_sched.sv
// Directed self-checking bench for maj_net_sched (also covers MAJ_SCHED_PERF_EN when defined).
module tb_maj_net_sched;
    localparam int NODES = 8;
    localparam int OPW   = 5;
    localparam int GW    = 15;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   exp_perf;

    maj_net_sched_if #(.NODES(NODES)) bus();
`ifdef MAJ_SCHED_PERF_EN
    logic [15:0] perf_cnt;
`endif

    maj_net_sched #(.NODES(NODES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MAJ_SCHED_PERF_EN
        ,
        .perf_cnt (perf_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [OPW-1:0] op(input logic inv, input logic [3:0] idx);
        return {inv, idx};
    endfunction

    function automatic logic [GW-1:0] ctrl(input logic [3:0] len, input logic [OPW-1:0] sel);
        return {6'b000000, len, sel};
    endfunction

    function automatic logic [GW-1:0] gate(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic [OPW-1:0] c);
        return {c, b, a};
    endfunction

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic chain_model(input logic [5:0] v);
        logic n0, n1;
        n0 = maj(v[0], v[1], v[2]);
        n1 = maj(~v[3], v[4], n0);
        return maj(n0, n1, v[5]);
    endfunction

    task automatic cfg_write(input logic [3:0] addr, input logic [GW-1:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        total++;
        if (bus.cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL cfg_write_ok addr=%0d got cfg_err=%b exp=0", addr, bus.cfg_err);
        end
    endtask

    // Called at a negedge; err_at >= 0 injects a rejected control write that many cycles after the accept.
    task automatic run_vec(input string name, input logic [5:0] xv, input logic exp_y, input int exp_lat, input int err_at);
        int n;
        bus.in_valid = 1'b1;
        bus.x        = xv;
        if (err_at == 0) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = 4'd8; bus.cfg_data = ctrl(4'd0, op(1'b1, 4'd0));
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL %s in_ready x=%b got=%b exp=1", name, xv, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        if (err_at == 0) begin
            bus.cfg_we = 1'b0;
            total++;
            if (bus.cfg_err !== 1'b1) begin
                bad++; $display("FAIL %s cfg_err got=%b exp=1", name, bus.cfg_err);
            end
        end
        while (bus.out_valid !== 1'b1 && n < 40) begin
            if (err_at == n) begin
                bus.cfg_we = 1'b1; bus.cfg_addr = 4'd8; bus.cfg_data = ctrl(4'd0, op(1'b1, 4'd0));
            end
            @(negedge clk);
            n++;
            if (err_at == n - 1) begin
                bus.cfg_we = 1'b0;
                total++;
                if (bus.cfg_err !== 1'b1) begin
                    bad++; $display("FAIL %s cfg_err got=%b exp=1", name, bus.cfg_err);
                end
            end
        end
        total++;
        if (n !== exp_lat) begin
            bad++; $display("FAIL %s latency x=%b got=%0d exp=%0d", name, xv, n, exp_lat);
        end
        total++;
        if (bus.y !== exp_y) begin
            bad++; $display("FAIL %s y x=%b got=%b exp=%b", name, xv, bus.y, exp_y);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_perf++;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL %s post_hs got rdy=%b vld=%b exp rdy=1 vld=0", name, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic check_perf(input string name);
`ifdef MAJ_SCHED_PERF_EN
        total++;
        if (perf_cnt !== exp_perf[15:0]) begin
            bad++; $display("FAIL %s perf_cnt got=%0d exp=%0d", name, perf_cnt, exp_perf);
        end
`endif
    endtask

    task automatic load_chain();
        cfg_write(4'd0, gate(op(1'b0, 4'd1), op(1'b0, 4'd2), op(1'b0, 4'd3)));
        cfg_write(4'd1, gate(op(1'b1, 4'd4), op(1'b0, 4'd5), op(1'b0, 4'd7)));
        cfg_write(4'd2, gate(op(1'b0, 4'd7), op(1'b0, 4'd8), op(1'b0, 4'd6)));
        cfg_write(4'd8, ctrl(4'd3, op(1'b0, 4'd9)));
    endtask

    task automatic test_reset();
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.y !== 1'b0 || bus.cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL reset got rdy=%b vld=%b y=%b err=%b exp 1 0 0 0", bus.in_ready, bus.out_valid, bus.y, bus.cfg_err);
        end
        check_perf("reset");
    endtask

    task automatic test_single_gate();
        cfg_write(4'd0, gate(op(1'b1, 4'd2), op(1'b0, 4'd3), op(1'b0, 4'd0)));
        cfg_write(4'd8, ctrl(4'd1, op(1'b0, 4'd7)));
        run_vec("gate_a", 6'b000100, 1'b1, 2, -1);
        run_vec("gate_b", 6'b000110, 1'b0, 2, -1);
    endtask

    task automatic test_len0();
        cfg_write(4'd8, ctrl(4'd0, op(1'b1, 4'd4)));
        run_vec("len0_a", 6'b000000, 1'b1, 1, -1);
        run_vec("len0_b", 6'b001000, 1'b0, 1, -1);
    endtask

    task automatic test_chain();
        load_chain();
        for (int v = 0; v < 64; v++) begin
            run_vec("chain", 6'(v), chain_model(6'(v)), 4, -1);
        end
        check_perf("chain");
    endtask

    task automatic test_len_saturate();
        cfg_write(4'd8, ctrl(4'd15, op(1'b0, 4'd9)));
        run_vec("len_sat", 6'b111111, 1'b1, 9, -1);
        cfg_write(4'd8, ctrl(4'd3, op(1'b0, 4'd9)));
    endtask

    task automatic test_back_to_back();
        int n;
        bus.in_valid = 1'b1;
        bus.x        = 6'b000111;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== 4) begin
            bad++; $display("FAIL hold latency got=%0d exp=4", n);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.y !== 1'b1 || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold cyc=%0d got vld=%b y=%b rdy=%b exp 1 1 0", c, bus.out_valid, bus.y, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_perf++;
        run_vec("b2b", 6'b101010, chain_model(6'b101010), 4, -1);
        check_perf("b2b");
    endtask

    task automatic test_cfg_err();
        run_vec("cfg_eval", 6'b000111, 1'b1, 4, 1);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 4'd9;
        bus.cfg_data = ctrl(4'd0, op(1'b1, 4'd0));
        @(negedge clk);
        bus.cfg_we = 1'b0;
        total++;
        if (bus.cfg_err !== 1'b1) begin
            bad++; $display("FAIL cfg_addr_hi got=%b exp=1", bus.cfg_err);
        end
        @(negedge clk);
        total++;
        if (bus.cfg_err !== 1'b0) begin
            bad++; $display("FAIL cfg_err_pulse got=%b exp=0", bus.cfg_err);
        end
        run_vec("cfg_after", 6'b011011, chain_model(6'b011011), 4, -1);
        run_vec("cfg_acc", 6'b000001, chain_model(6'b000001), 4, 0);
    endtask

    task automatic test_reset_mid();
        run_vec("pre_rst", 6'b111111, 1'b1, 4, -1);
        bus.in_valid = 1'b1;
        bus.x        = 6'b111111;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_perf = 0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.y !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_rst got vld=%b y=%b rdy=%b exp 0 0 1", bus.out_valid, bus.y, bus.in_ready);
        end
        check_perf("mid_rst");
        repeat (5) @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL mid_rst_quiet got vld=%b exp=0", bus.out_valid);
        end
        run_vec("post_rst", 6'b111111, 1'b0, 1, -1);
        check_perf("post_rst");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        total         = 0;
        bad           = 0;
        exp_perf      = 0;
        bus.in_valid  = 1'b0;
        bus.x         = 6'b000000;
        bus.out_ready = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 4'd0;
        bus.cfg_data  = {GW{1'b0}};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single_gate();
        test_len0();
        test_chain();
        test_len_saturate();
        test_back_to_back();
        test_cfg_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/maj_net_sched.md
# maj_net_sched

Sequential evaluator for 6-input, single-output majority-inverter networks, built around one shared 3-input majority unit. A small program store holds up to NODES majority gates in topological order. Each accepted input vector is evaluated one gate per cycle, and the selected signal is returned through a valid/ready output. The block time-multiplexes a single MAJ datapath so that configurable MIG test functions run in hardware, without a dedicated gate per node.

## Interface
- NODES, 8, max gates per program (1..16)
- SW (derived), $clog2(NODES+7), signal-index width; OPW = SW+1 operand width; AW = $clog2(NODES+1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector offered
- in_ready  out  1  block can accept a vector
- x  in  6  input vector; x[k] is primary input k
- out_valid  out  1  result y valid
- out_ready  in  1  consumer takes y
- y  out  1  evaluated function value
- cfg_we  in  1  config write strobe
- cfg_addr  in  AW  0..NODES-1 = gate slot; NODES = control word
- cfg_data  in  3*OPW  gate: {opc, opb, opa}; control: {len[AW-1:0], out_sel[OPW-1:0]} in low bits
- cfg_err  out  1  one-cycle pulse when a write is rejected

## Operation
- Signal index space:
  - 0 = constant 0
  - 1..6 = x0..x5
  - 7+j = node j
  - Indices above 6+NODES read as 0
- Operand = {inv, idx[SW-1:0]}; value = sig[idx] ^ inv. An inverted constant 0 gives constant 1.
- Gate j computes node[j] = MAJ(opa, opb, opc) = ab | ac | bc.
- Control word fields:
  - len: number of gates executed. Writes above NODES saturate to NODES.
  - out_sel: operand driving y.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready: latch x, clear all node registers to 0, set pc=0.
    - Go to EVAL if len>0, else DONE.
  - EVAL:
    - Each cycle: node[pc] <= MAJ of gate pc's operands, read from current registers; pc++.
    - After writing gate len-1, go to DONE.
    - An operand referencing node j with j>=pc reads its current value, which is 0 since clear.
  - DONE:
    - out_valid=1; y = out_sel value, registered on entry.
    - On out_ready, go to IDLE.
- Config:
  - cfg_we is accepted only in IDLE and only when no accept occurs in the same cycle.
  - Otherwise the write is dropped, the program is unchanged, and cfg_err pulses the next cycle.
  - cfg_addr > NODES is dropped with cfg_err.
- Reset values: program store and len/out_sel all 0, state IDLE, in_ready=1, out_valid=0, y=0, cfg_err=0, pc=0, node registers 0.
- Reset mid-operation: the evaluation is abandoned, no out_valid is produced, and the program is cleared.

## Timing
- Accept at edge T; out_valid rises at edge T+len+1. For len=0, out_valid rises at T+1.
- One gate is written per cycle. There are no bubbles in EVAL.
- in_ready=0 from the accept edge until the edge after the out handshake. There is no overlap between vectors.
- y and out_valid hold stable while out_ready=0.
- The out handshake at edge H returns the block to IDLE: in_ready=1 after H, and the next accept is possible at H+1.
- A config write in IDLE takes effect for any vector accepted on a later edge.

## Configuration
- MAJ_SCHED_PERF_EN:
  - Defined: adds output perf_cnt (16 bits) counting completed out handshakes. It saturates at 16'hFFFF and resets to 0.
  - Undefined: the port and the counter are absent; behaviour is otherwise identical.

## Test plan
- Program gate0 = {opa=~x1 (inv=1, idx 2), opb=x2 (idx 3), opc=const0}, len=1, out_sel=node0 (idx 7).
  - x=6'b000100 -> y=1, with out_valid exactly 2 cycles after accept.
  - x=6'b000110 -> y=0.
- len=0, out_sel=~x3 (inv=1, idx 4): x=6'b000000 -> y=1 one cycle after accept; x=6'b001000 -> y=0.
- Chain of 3 gates, with node2 = MAJ(node0, node1, x5), len=3.
  - Check y against a software model for all 64 x values.
  - Latency is always 4 cycles.
- Hold out_ready=0 for 5 cycles in DONE -> y, out_valid stable; in_ready=0; then out_ready=1 -> IDLE, next vector accepted the following cycle.
- cfg_we during EVAL, and cfg_addr=NODES+1 in IDLE -> cfg_err pulse each; program and result unchanged.
- Assert rst_n low mid-EVAL -> out_valid=0, y=0, in_ready=1 after release; len=0 and out_sel=0, so the next vector yields y=0. With MAJ_SCHED_PERF_EN: perf_cnt=0 after reset, +1 per handshake.
